// File: rtl/track_line_builder.sv
// track_line_builder: per-frame builder of the track scanline table.
// On frame_start it walks the rows from nearest (ROWS-1) to the horizon (0),
// computing one packed edge word per row, and stores it in a row RAM that the
// plotter reads through a registered 1-cycle read port.
// Optional feature macro: TRACK_DOUBLE_BUFFER_EN (two RAM banks, the plotter
// only sees complete tables). Default build: a single shared bank.
module track_line_builder #(
  parameter int ROWS        = 60,
  parameter int WINDOW_W    = 160,
  parameter int CENTER      = 80,
  parameter int MIN_HW      = 8,
  parameter int CURVE_SHIFT = 6
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [7:0]  curve,
  input  logic [7:0]  player_x,
  input  logic [9:0]  scroll,
  input  logic [8:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_CALC  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      r_q, r_d;
  logic signed [20:0] acc_q, acc_d;
  logic signed [20:0] step_q, step_d;
  logic signed [7:0]  curve_q, curve_d;
  logic signed [7:0]  px_q, px_d;
  logic [9:0]         scroll_q, scroll_d;
  logic [31:0]        word_q, word_d;
  logic               overrun_q, overrun_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               last_write;

  logic signed [20:0] curve_ext, px_ext, hw, bw, c;
  logic [9:0]         stripe_sum;
  logic [31:0]        row_word;

  // Clamp a signed x coordinate into the visible window [0, WINDOW_W].
  function automatic logic [9:0] clamp_x(input logic signed [20:0] v);
    if (v < 21'sd0) return 10'd0;
    else if (v > 21'(WINDOW_W)) return 10'(WINDOW_W);
    else return v[9:0];
  endfunction

  assign busy       = (state_q != S_IDLE);
  assign last_write = (state_q == S_WRITE) && (r_q == '0);
  assign done       = last_write;
  assign overrun    = overrun_q;
  assign rd_data    = rd_data_q;

  // Row geometry: perspective half-width, bump width and curve-bent centre.
  always_comb begin
    curve_ext  = {{13{curve_q[7]}}, curve_q};
    px_ext     = {{13{px_q[7]}}, px_q};
    hw         = 21'(MIN_HW) + signed'({{(21-AW){1'b0}}, r_q});
    bw         = (hw >>> 3) + 21'sd1;
    c          = 21'(CENTER) - px_ext + (acc_q >>> CURVE_SHIFT);
    stripe_sum = {{(10-AW){1'b0}}, r_q} + scroll_q;
    row_word   = {stripe_sum[2], 1'b0, clamp_x(c + hw), clamp_x(c - hw - bw),
                  clamp_x(c - hw)};
  end

  // Build sequencer; acc tracks curve*d*d through the running odd-step sum.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    acc_d     = acc_q;
    step_d    = step_q;
    curve_d   = curve_q;
    px_d      = px_q;
    scroll_d  = scroll_q;
    word_d    = word_q;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_LATCH;
      end
      S_LATCH: begin
        curve_d  = curve;
        px_d     = player_x;
        scroll_d = scroll;
        r_d      = AW'(ROWS - 1);
        acc_d    = '0;
        step_d   = {{13{curve[7]}}, curve};
        state_d  = S_CALC;
      end
      S_CALC: begin
        word_d  = row_word;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        acc_d  = acc_q + step_q;
        step_d = step_q + (curve_ext <<< 1);
        r_d    = r_q - AW'(1);
        if (last_write) state_d = frame_start ? S_LATCH : S_IDLE;
        else            state_d = S_CALC;
      end
      default: state_d = S_IDLE;
    endcase
    // A start request that lands on the done cycle is a legal back-to-back build.
    if (frame_start && busy && !last_write) overrun_d = 1'b1;
  end

  // Control state: FSM and sticky overrun flag.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= overrun_d;
    end
  end

  // Datapath registers carry no reset; the FSM qualifies every use.
  always_ff @(posedge pixel_clk) begin
    r_q      <= r_d;
    acc_q    <= acc_d;
    step_q   <= step_d;
    curve_q  <= curve_d;
    px_q     <= px_d;
    scroll_q <= scroll_d;
    word_q   <= word_d;
  end

`ifdef TRACK_DOUBLE_BUFFER_EN
  logic        rd_bank_q, rd_bank_d;
  logic [31:0] mem [2][ROWS];

  // Flip to the freshly written bank once its last row lands.
  always_comb rd_bank_d = last_write ? ~rd_bank_q : rd_bank_q;

  // An aborted build must not expose its half-written bank, so a reset
  // arriving mid-build leaves the bank selector alone.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      if (state_q == S_IDLE) rd_bank_q <= 1'b0;
    end else begin
      rd_bank_q <= rd_bank_d;
    end
  end

  // Builds always target the bank the plotter is not reading.
  always_ff @(posedge pixel_clk) begin
    if (state_q == S_WRITE) mem[~rd_bank_q][r_q] <= word_q;
  end

  // Read mux; out-of-range rows read as zero.
  always_comb begin
    rd_data_d = '0;
    if (rd_addr < 9'(ROWS)) rd_data_d = mem[rd_bank_q][rd_addr[AW-1:0]];
  end
`else
  logic [31:0] mem [ROWS];

  // Single shared bank; a same-cycle read of the row being written sees the old word.
  always_ff @(posedge pixel_clk) begin
    if (state_q == S_WRITE) mem[r_q] <= word_q;
  end

  // Read mux; out-of-range rows read as zero.
  always_comb begin
    rd_data_d = '0;
    if (rd_addr < 9'(ROWS)) rd_data_d = mem[rd_addr[AW-1:0]];
  end
`endif

  // Registered read port.
  always_ff @(posedge pixel_clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

endmodule
